mux2_chip_tester: RTL



---
 rtl/mux2_chip_tester.sv | 109 ++++++++++
 1 files changed

// File: rtl/mux2_chip_tester.sv
// Stimulus/response stage that walks a 2:1 mux through all 8 {s,y,x} vectors and counts mismatches.
// Optional first-failure capture is enabled with `define MUX2_TESTER_FIRST_FAIL_EN.
module mux2_chip_tester #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       m_in,
  output logic       x_out,
  output logic       y_out,
  output logic       s_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] vector,
  output logic [1:0] fsm_state
`ifdef MUX2_TESTER_FIRST_FAIL_EN
  ,
  output logic       first_fail_valid,
  output logic [2:0] first_fail_vec
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] settle_cnt;
  logic       accept;
  logic       expected;
  logic       mismatch;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    mismatch   = 1'b0;
    expected   = vector[2] ? vector[1] : vector[0];
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_next = CHECK;
      end
      CHECK: begin
        mismatch   = (m_in != expected);
        state_next = (vector == 3'd7) ? DONE : SETTLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The drive outputs are the vector register itself, so they only move on the start edge or when leaving CHECK.
  always_ff @(posedge clock) begin
    if (reset) begin
      vector     <= 3'd0;
      err_count  <= 4'd0;
      settle_cnt <= 4'd0;
    end else if (accept) begin
      vector     <= 3'd0;
      err_count  <= 4'd0;
      settle_cnt <= 4'd0;
    end else if (state == SETTLE) begin
      settle_cnt <= settle_cnt + 4'd1;
    end else if (state == CHECK) begin
      if (mismatch) err_count <= err_count + 4'd1;
      if (vector != 3'd7) begin
        vector     <= vector + 3'd1;
        settle_cnt <= 4'd0;
      end
    end
  end

`ifdef MUX2_TESTER_FIRST_FAIL_EN
  always_ff @(posedge clock) begin
    if (reset || accept) begin
      first_fail_valid <= 1'b0;
      first_fail_vec   <= 3'd0;
    end else if (mismatch && !first_fail_valid) begin
      first_fail_valid <= 1'b1;
      first_fail_vec   <= vector;
    end
  end
`endif

  assign {s_out, y_out, x_out} = vector;
  assign busy      = (state == SETTLE) || (state == CHECK);
  assign done      = (state == DONE);
  assign pass      = done && (err_count == 4'd0);
  assign fsm_state = state;

endmodule
